// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative shift-add multiply.
// Optional restoring divider (DIVU/REMU) is compiled in when ALU_MC_DIV_EN is defined.
module alu_mc #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic [4:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic             div_zero,
   output logic [1:0]       dbg_state
);

   // Handshake: a request is taken on a rising edge with in_valid && in_ready; a result
   // is consumed on a rising edge with out_valid && out_ready. in_ready is 1 only in IDLE,
   // out_valid is 1 only in DONE, so the two never complete in the same cycle.
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam int            CW   = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_q, b_q, acc;
   logic [WIDTH-1:0] alu_res;
   logic [SHW-1:0]   sh;
   logic             is_iter;
   logic [WIDTH-1:0] step_a, step_b, step_acc, step_res;
   logic             step_dz;

`ifdef ALU_MC_DIV_EN
   logic             div_q, rem_q;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] rem_diff, rem_nx;
   logic             ge;
`endif

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign dbg_state = state;
   assign sh        = src_b[SHW-1:0];

`ifdef ALU_MC_DIV_EN
   assign is_iter = (op == 5'h0B) || (op == 5'h0C) || (op == 5'h0D);
`else
   assign is_iter = (op == 5'h0B);
`endif

   always_comb begin
      alu_res = '0;
      case (op)
         5'h00: alu_res = src_a;
         5'h01: alu_res = src_a + src_b;
         5'h02: alu_res = src_a ^ src_b;
         5'h03: alu_res = src_a | src_b;
         5'h04: alu_res = src_a & src_b;
         5'h05: alu_res = src_a - src_b;
         5'h06: alu_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
         5'h07: alu_res = src_a << sh;
         5'h08: alu_res = src_a >> sh;
         5'h09: alu_res = WIDTH'($signed(src_a) >>> sh);
         5'h0A: alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         default: alu_res = '0;
      endcase
   end

   // One iteration: multiply adds the shifted multiplicand when the current multiplier
   // bit is set; division shifts one dividend bit into the partial remainder.
   always_comb begin
      step_a   = a_q << 1;
      step_b   = b_q >> 1;
      step_acc = acc + (b_q[0] ? a_q : '0);
      step_res = step_acc;
      step_dz  = 1'b0;
`ifdef ALU_MC_DIV_EN
      rem_sh   = {acc, a_q[WIDTH-1]};
      ge       = (rem_sh >= {1'b0, b_q});
      rem_diff = rem_sh[WIDTH-1:0] - b_q;
      rem_nx   = ge ? rem_diff : rem_sh[WIDTH-1:0];
      if (div_q) begin
         step_acc = rem_nx;
         step_a   = {a_q[WIDTH-2:0], ge};
         step_b   = b_q;
         step_res = rem_q ? rem_nx : {a_q[WIDTH-2:0], ge};
         step_dz  = (b_q == '0);
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         res      <= '0;
         div_zero <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         acc      <= '0;
`ifdef ALU_MC_DIV_EN
         div_q    <= 1'b0;
         rem_q    <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  a_q <= src_a;
                  b_q <= src_b;
                  acc <= '0;
                  cnt <= '0;
`ifdef ALU_MC_DIV_EN
                  div_q <= (op == 5'h0C) || (op == 5'h0D);
                  rem_q <= (op == 5'h0D);
`endif
                  if (is_iter) begin
                     state <= S_BUSY;
                  end else begin
                     res      <= alu_res;
                     div_zero <= 1'b0;
                     state    <= S_DONE;
                  end
               end
            end
            S_BUSY: begin
               a_q <= step_a;
               b_q <= step_b;
               acc <= step_acc;
               cnt <= cnt + CW'(1);
               if (cnt == LAST) begin
                  cnt      <= '0;
                  res      <= step_res;
                  div_zero <= step_dz;
                  state    <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc (WIDTH=32): directed cases plus randomized ops against a behavioural model.
module tb_alu_mc;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] src_a = '0;
   logic [31:0] src_b = '0;
   logic [4:0]  op = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] res;
   logic        div_zero;
   logic [1:0]  dbg_state;

   int checks = 0;
   int failures = 0;

   alu_mc #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .src_a(src_a), .src_b(src_b), .op(op), .out_valid(out_valid),
      .out_ready(out_ready), .res(res), .div_zero(div_zero), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic dz, output int lat);
      logic [63:0] prod;
      r = '0; dz = 1'b0; lat = 1;
      case (o)
         5'h00: r = a;
         5'h01: r = a + b;
         5'h02: r = a ^ b;
         5'h03: r = a | b;
         5'h04: r = a & b;
         5'h05: r = a - b;
         5'h06: r = (a < b) ? 32'd1 : 32'd0;
         5'h07: r = a << b[4:0];
         5'h08: r = a >> b[4:0];
         5'h09: r = $unsigned($signed(a) >>> b[4:0]);
         5'h0A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         5'h0B: begin prod = 64'(a) * 64'(b); r = prod[31:0]; lat = 33; end
`ifdef ALU_MC_DIV_EN
         5'h0C: begin lat = 33; dz = (b == 0); r = (b == 0) ? 32'hFFFF_FFFF : a / b; end
         5'h0D: begin lat = 33; dz = (b == 0); r = (b == 0) ? a : a % b; end
`endif
         default: r = '0;
      endcase
   endfunction

   // Issue one request, wait for the result, hold it for 'stall' cycles, then consume it.
   task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int stall);
      logic [31:0] er;
      logic        edz;
      int          elat, lat;
      model(o, a, b, er, edz, elat);
      @(negedge clk);
      chk("ready_before_accept", in_ready, 1);
      in_valid = 1'b1; op = o; src_a = a; src_b = b; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0; src_a = $urandom; src_b = $urandom; op = 5'($urandom);
      lat = 1;
      while (!out_valid && lat < 100) begin
         if (in_ready !== 1'b0) chk("ready_low_busy", in_ready, 0);
         @(posedge clk); #1;
         lat++;
      end
      chk("out_valid", out_valid, 1);
      chk($sformatf("latency_op%0h", o), lat, elat);
      chk($sformatf("res_op%0h", o), res, er);
      chk($sformatf("div_zero_op%0h", o), div_zero, edz);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         in_valid = 1'b1; src_a = $urandom; src_b = $urandom; op = 5'($urandom);
         @(posedge clk); #1;
         chk("hold_valid", out_valid, 1);
         chk("hold_res", res, er);
         chk("hold_ready", in_ready, 0);
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("consumed_valid", out_valid, 0);
      chk("consumed_ready", in_ready, 1);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_res", res, 0);
      chk("rst_div_zero", div_zero, 0);

      run_op(5'h09, 32'h8000_0000, 32'd4, 0);
      chk("asr_directed", res, 32'hF800_0000);
      run_op(5'h0A, 32'hFFFF_FFFF, 32'd1, 0);
      chk("slt_directed", res, 32'd1);
      run_op(5'h0B, 32'h0001_0003, 32'h0001_0005, 0);
      chk("mul_directed", res, 32'h0008_000F);
      run_op(5'h01, 32'hFFFF_FFFF, 32'd2, 5);
      chk("add_wrap_directed", res, 32'd1);
`ifdef ALU_MC_DIV_EN
      run_op(5'h0C, 32'd100, 32'd7, 0);
      chk("divu_directed", res, 32'd14);
      run_op(5'h0D, 32'd100, 32'd7, 0);
      chk("remu_directed", res, 32'd2);
      run_op(5'h0C, 32'd100, 32'd0, 1);
      chk("divu_zero_res", res, 32'hFFFF_FFFF);
      chk("divu_zero_flag", div_zero, 1);
`else
      run_op(5'h0C, 32'd100, 32'd7, 0);
      chk("divu_absent", res, 32'd0);
      chk("divu_absent_dz", div_zero, 0);
`endif
      run_op(5'h1F, 32'h1234_5678, 32'h9ABC_DEF0, 0);

      // Reset in the middle of a multiply abandons it.
      @(negedge clk);
      in_valid = 1'b1; op = 5'h0B; src_a = 32'd12345; src_b = 32'd678;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_res", res, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("midrst_ready", in_ready, 1);
      repeat (40) @(posedge clk);
      #1;
      chk("midrst_no_result", out_valid, 0);

      for (int n = 0; n < 60; n++) begin
         logic [4:0]  ro;
         logic [31:0] ra, rb;
         ro = 5'($urandom_range(0, 15));
         if (n % 8 == 7) ro = 5'($urandom_range(16, 31));
         ra = $urandom;
         rb = (n % 5 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         run_op(ro, ra, rb, $urandom_range(0, 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width; legal values 8, 16, 32, 64.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width taken from src_b[SHW-1:0].
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 in_valid  input  1  request present on src_a/src_b/op.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 src_a  input  WIDTH  first operand.
REQ-008 src_b  input  WIDTH  second operand.
REQ-009 op  input  5  operation code.
REQ-010 out_valid  output  1  res/div_zero hold a completed result.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 res  output  WIDTH  registered result.
REQ-013 div_zero  output  1  completed result came from a divide or remainder with src_b == 0.

Function
REQ-014 States: IDLE, BUSY, DONE; in_ready SHALL be 1 exactly when the state is IDLE.
REQ-015 Accept = in_valid && in_ready at a rising edge; the block SHALL latch src_a, src_b and op on accept; later input changes SHALL have no effect.
REQ-016 Single-cycle ops SHALL be: 0x0 a; 0x1 a+b; 0x2 a^b; 0x3 a|b; 0x4 a&b; 0x5 a-b; 0x6 unsigned a<b gives 1, else 0; 0x7 a<<b[SHW-1:0]; 0x8 logical a>>b[SHW-1:0]; 0x9 arithmetic a>>>b[SHW-1:0]; 0xA signed a<b gives 1, else 0.
REQ-017 Add and subtract SHALL wrap modulo 2^WIDTH, with no carry or overflow output.
REQ-018 Op codes 0xE-0x1F SHALL give res=0 and div_zero=0 as a single-cycle op.
REQ-019 Single-cycle op: IDLE->DONE on the accept edge; out_valid SHALL be 1 in the cycle after accept.
REQ-020 0xB MUL SHALL give the low WIDTH bits of unsigned a*b, computed by iterative shift-add at one bit per cycle.
REQ-021 Iterative op: IDLE->BUSY on accept; BUSY SHALL last exactly WIDTH cycles, counted by an internal counter; BUSY->DONE on the WIDTH-th BUSY edge; out_valid SHALL first be 1 WIDTH+1 cycles after accept.
REQ-022 DONE: out_valid=1, and res and div_zero SHALL stay stable until out_ready=1; DONE->IDLE on the edge where out_ready=1.
REQ-023 in_ready=0 in DONE: a new request cannot be accepted in the same cycle a result is consumed; the next accept is possible no earlier than one cycle after the consume.
REQ-024 in_valid SHALL be ignored while in BUSY or DONE.
REQ-025 out_ready SHALL be ignored outside DONE.
REQ-026 res and div_zero SHALL change only on the edge that enters DONE, or on reset.

Reset
REQ-027 When rst_n=0 at a rising edge: state=IDLE, res=0, div_zero=0, out_valid=0, iteration counter=0.
REQ-028 Reset asserted in BUSY or DONE SHALL abandon the operation with no result delivered; in_ready SHALL be 1 in the cycle after reset is released.

Configuration
REQ-029 Macro ALU_MC_DIV_EN, when defined, SHALL compile in 0xC DIVU (unsigned quotient) and 0xD REMU (unsigned remainder), computed by restoring division at one bit per cycle with the REQ-021 iterative timing.
REQ-030 With ALU_MC_DIV_EN defined and src_b=0: DIVU res = all ones, REMU res = src_a, div_zero=1, with full iterative latency.
REQ-031 Without ALU_MC_DIV_EN: ops 0xC and 0xD SHALL behave as REQ-018, and no divider logic SHALL be present.

Verification (WIDTH=32)
REQ-032 Reset mid-MUL: accept MUL, assert rst_n=0 at BUSY cycle 10 -> out_valid=0, res=0, in_ready=1 after reset is released.
REQ-033 op=0x9, a=0x80000000, b=4 -> res=0xF8000000 one cycle after accept; op=0xA, a=0xFFFFFFFF, b=1 -> res=1.
REQ-034 op=0xB, a=0x0001_0003, b=0x0001_0005 -> res=0x0008_000F, out_valid first high 33 cycles after accept, in_ready=0 throughout.
REQ-035 ALU_MC_DIV_EN defined: op=0xC, a=100, b=7 -> res=14; op=0xD -> res=2; op=0xC, b=0 -> res=0xFFFFFFFF, div_zero=1.
REQ-036 Backpressure: out_ready=0 for 5 cycles after op=0x1, a=0xFFFFFFFF, b=2 -> res=1 held stable, in_valid pulses ignored, IDLE entered on the out_ready edge.
REQ-037 Build without ALU_MC_DIV_EN: op=0xC, a=100, b=7 -> res=0 one cycle after accept, div_zero=0.
